// File: rtl/pool1_relu_if.sv
`default_nettype none
// ============================================================================
// pool1_relu_if : pixel-in / pooled-result-out stream bundle for pool1_relu
// Rev 1.0
// ============================================================================
interface pool1_relu_if #(
   parameter int ADDR_W = 9
) ();
   logic              start;
   logic              in_valid;
   logic [7:0]        in_pixel;
   logic              out_valid;
   logic [7:0]        out_pixel;
   logic [ADDR_W-1:0] out_addr;
   logic              done;

   modport master (
      output start, in_valid, in_pixel,
      input  out_valid, out_pixel, out_addr, done
   );

   modport slave (
      input  start, in_valid, in_pixel,
      output out_valid, out_pixel, out_addr, done
   );
endinterface
`default_nettype wire

// File: rtl/pool1_relu.sv
`default_nettype none
// ============================================================================
// pool1_relu : streaming ReLU + 2x2/stride-2 max-pool behind conv1
// Rev 1.0
// ============================================================================
module pool1_relu #(
   parameter int IN_H   = 14,
   parameter int IN_W   = 13,
   parameter int CHAN   = 10,
   parameter int PH     = IN_H / 2,
   parameter int PW     = IN_W / 2,
   parameter int ADDR_W = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   pool1_relu_if.slave  bus
);

   localparam int c_col_w = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam int c_row_w = (IN_H > 1) ? $clog2(IN_H) : 1;
   localparam int c_ch_w  = (CHAN > 1) ? $clog2(CHAN + 1) : 1;
   localparam int c_lb_w  = (PW > 1) ? $clog2(PW) : 1;

   localparam logic [c_col_w-1:0] c_col_last = c_col_w'(IN_W - 1);
   localparam logic [c_row_w-1:0] c_row_last = c_row_w'(IN_H - 1);
   localparam logic [c_ch_w-1:0]  c_ch_last  = c_ch_w'(CHAN - 1);
   localparam logic [c_col_w:0]   c_col_lim  = (c_col_w + 1)'(2 * PW);
   localparam logic [c_row_w:0]   c_row_lim  = (c_row_w + 1)'(2 * PH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [c_col_w-1:0]  r_col;
   logic [c_row_w-1:0]  r_row;
   logic [c_ch_w-1:0]   r_ch;
   logic [ADDR_W-1:0]   r_addr;
   logic [7:0]          r_hold;
   logic [7:0]          r_linebuf [PW];
   logic                r_out_valid;
   logic [7:0]          r_out_pixel;
   logic [ADDR_W-1:0]   r_out_addr;

   logic                w_accept;
   logic                w_last;
   logic                w_in_win;
   logic [c_lb_w-1:0]   w_lb_idx;
   logic [7:0]          w_relu;
   logic [7:0]          w_pair;
   logic [7:0]          w_lb;
   logic [7:0]          w_pool;

   assign w_accept = (r_state == S_RUN) && bus.in_valid && !bus.start;
   assign w_last   = w_accept && (r_col == c_col_last) && (r_row == c_row_last)
                     && (r_ch == c_ch_last);
   assign w_in_win = ({1'b0, r_col} < c_col_lim) && ({1'b0, r_row} < c_row_lim);
   assign w_lb_idx = c_lb_w'(r_col >> 1);

   // After ReLU every operand is 0..127, so unsigned compares order them correctly.
   assign w_relu = bus.in_pixel[7] ? 8'd0 : bus.in_pixel;
   assign w_pair = (r_hold > w_relu) ? r_hold : w_relu;
   assign w_lb   = r_linebuf[w_lb_idx];
   assign w_pool = (w_lb > w_pair) ? w_lb : w_pair;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
         S_RUN: begin
            if (bus.start) begin
               w_state_nxt = S_RUN;
            end else if (w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE:  if (bus.start) w_state_nxt = S_RUN;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col       <= '0;
         r_row       <= '0;
         r_ch        <= '0;
         r_addr      <= '0;
         r_hold      <= '0;
         r_out_valid <= 1'b0;
         r_out_pixel <= '0;
         r_out_addr  <= '0;
         for (int i = 0; i < PW; i++) begin
            r_linebuf[i] <= '0;
         end
      end else begin
         r_out_valid <= 1'b0;
         if (bus.start) begin
            r_col  <= '0;
            r_row  <= '0;
            r_ch   <= '0;
            r_addr <= '0;
         end else if (w_accept) begin
            if (r_col == c_col_last) begin
               r_col <= '0;
               if (r_row == c_row_last) begin
                  r_row <= '0;
                  r_ch  <= r_ch + 1'b1;
               end else begin
                  r_row <= r_row + 1'b1;
               end
            end else begin
               r_col <= r_col + 1'b1;
            end

            // Odd trailing row/column fall outside every pooling window.
            if (w_in_win) begin
               if (!r_col[0]) begin
                  r_hold <= w_relu;
               end else if (!r_row[0]) begin
                  r_linebuf[w_lb_idx] <= w_pair;
               end else begin
                  r_out_valid <= 1'b1;
                  r_out_pixel <= w_pool;
                  r_out_addr  <= r_addr;
                  r_addr      <= r_addr + 1'b1;
               end
            end
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_pixel = r_out_pixel;
   assign bus.out_addr  = r_out_addr;
   assign bus.done      = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pool1_relu.sv
`default_nettype none
// ============================================================================
// tb_pool1_relu : scoreboard bench for pool1_relu (directed frames)
// Rev 1.0
// ============================================================================
module tb_pool1_relu;

   localparam int IN_H   = 14;
   localparam int IN_W   = 13;
   localparam int CHAN   = 10;
   localparam int PH     = 7;
   localparam int PW     = 6;
   localparam int ADDR_W = 9;
   localparam int CH_PIX = IN_H * IN_W;
   localparam int CH_OUT = PH * PW;
   localparam int FRAME  = CH_PIX * CHAN;

   typedef struct {
      int addr;
      int pix;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pool1_relu_if #(.ADDR_W(ADDR_W)) bus ();

   pool1_relu #(
      .IN_H(IN_H), .IN_W(IN_W), .CHAN(CHAN), .PH(PH), .PW(PW), .ADDR_W(ADDR_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   n_out    = 0;
   int   n_exp    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
         n_out++;
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out: actual addr=%0d pix=%0d required no output",
                     bus.out_addr, bus.out_pixel);
         end else begin
            e = q.pop_front();
            chk("out_addr", int'(bus.out_addr), e.addr);
            chk("out_pixel", int'(bus.out_pixel), e.pix);
            chk("out_latency", cyc, e.cyc);
         end
      end
   end

   // kind 0: all -5; kind 1: ramp r+c with 127 in the discarded column;
   // kind 2: ramp with two hand-placed extreme windows at the top-left of ch0.
   function automatic int pix_val(input int kind, input int ch, input int r, input int c);
      int v;
      v = (c == IN_W - 1) ? 127 : r + c;
      if (kind == 0) begin
         v = -5;
      end else if (kind == 2 && ch == 0 && r < 2 && c < 4) begin
         case (r * 4 + c)
            0:       v = -128;
            1:       v = 127;
            2:       v = -128;
            3:       v = -1;
            4:       v = 0;
            5:       v = 5;
            6:       v = -128;
            default: v = -1;
         endcase
      end
      return v;
   endfunction

   function automatic int exp_val(input int kind, input int ch, input int pr, input int pc);
      if (kind == 0) return 0;
      if (kind == 2 && ch == 0 && pr == 0 && pc == 0) return 127;
      if (kind == 2 && ch == 0 && pr == 0 && pc == 1) return 0;
      return 2 * pr + 2 * pc + 2;
   endfunction

   task automatic drive(input bit st, input bit v, input int px);
      bus.start    = st;
      bus.in_valid = v;
      bus.in_pixel = 8'(px);
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
   endtask

   task automatic send_frame(input int kind, input int npix, input bit bubbles);
      for (int i = 0; i < npix; i++) begin
         int ch, rem, r, c;
         exp_t e;
         ch  = i / CH_PIX;
         rem = i % CH_PIX;
         r   = rem / IN_W;
         c   = rem % IN_W;
         if (r % 2 == 1 && c % 2 == 1 && c < 2 * PW && r < 2 * PH) begin
            e.addr = ch * CH_OUT + (r / 2) * PW + c / 2;
            e.pix  = exp_val(kind, ch, r / 2, c / 2);
            e.cyc  = cyc + 1;
            q.push_back(e);
            n_exp++;
         end
         if (i == FRAME - 1) chk("done_before_last", int'(bus.done), 0);
         drive(1'b0, 1'b1, pix_val(kind, ch, r, c));
         if (i == FRAME - 1) chk("done_at_last", int'(bus.done), 1);
         if (bubbles) drive(1'b0, 1'b0, 0);
      end
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 0);
      chk({tag, "_queue_empty"}, q.size(), 0);
      chk({tag, "_out_count"}, n_out, n_exp);
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_pixel = 8'd0;
      #22;
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_pixel", int'(bus.out_pixel), 0);
      chk("rst_out_addr", int'(bus.out_addr), 0);
      chk("rst_done", int'(bus.done), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int k = 0; k < 20; k++) drive(1'b0, 1'b1, 7);
      chk("idle_done", int'(bus.done), 0);
      drain("idle");

      drive(1'b1, 1'b0, 0);
      send_frame(0, FRAME, 1'b0);
      drain("neg");
      chk("neg_done_held", int'(bus.done), 1);

      for (int k = 0; k < 5; k++) drive(1'b0, 1'b1, 50);
      chk("done_state_done", int'(bus.done), 1);
      drain("done_state");

      drive(1'b1, 1'b0, 0);
      chk("start_clears_done", int'(bus.done), 0);
      send_frame(1, FRAME, 1'b0);
      drain("ramp");

      drive(1'b1, 1'b0, 0);
      send_frame(1, FRAME, 1'b1);
      drain("bubble");

      drive(1'b1, 1'b0, 0);
      send_frame(2, FRAME, 1'b0);
      drain("extreme");

      // Abort after 500 pixels; the restart pulse carries a pixel that must be dropped.
      drive(1'b1, 1'b0, 0);
      send_frame(1, 500, 1'b0);
      drain("abort");
      drive(1'b1, 1'b1, 99);
      chk("restart_no_done", int'(bus.done), 0);
      send_frame(1, FRAME, 1'b0);
      drain("restart");

      drive(1'b1, 1'b0, 0);
      send_frame(1, 300, 1'b0);
      drain("pre_reset");
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", int'(bus.out_valid), 0);
      chk("midrst_out_pixel", int'(bus.out_pixel), 0);
      chk("midrst_out_addr", int'(bus.out_addr), 0);
      chk("midrst_done", int'(bus.done), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) drive(1'b0, 1'b1, 3);
      chk("post_rst_done", int'(bus.done), 0);
      drain("post_rst");

      drive(1'b1, 1'b0, 0);
      send_frame(1, FRAME, 1'b0);
      drain("final");
      chk("final_done", int'(bus.done), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pool1_relu.md
Name: pool1_relu

Overview:
- Streaming ReLU + 2x2/stride-2 max-pool stage directly downstream of conv1.
- Consumes conv1's 8-bit signed output stream in channel-major order: channel outer, then row, then column.
- Emits the pooled feature map as a stream with a linear address, ready for the next layer's buffer.
- Holds one line buffer of half-row partial maxima; no full-frame storage.

Parameters:
- IN_H, 14, input feature-map rows (conv1 output height)
- IN_W, 13, input feature-map columns (conv1 output width)
- CHAN, 10, number of channels
- PH, IN_H/2, pooled rows (floor)
- PW, IN_W/2, pooled columns (floor)
- ADDR_W, 9, output address width; must satisfy 2^ADDR_W >= PH*PW*CHAN (420 with defaults)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; arms the block for a new frame
- in_valid  in  1  in_pixel carries a conv1 output this cycle
- in_pixel  in  8  signed conv1 output pixel
- out_valid  out  1  out_pixel/out_addr valid this cycle (one-cycle pulse per result)
- out_pixel  out  8  pooled value, range 0..127
- out_addr  out  ADDR_W  ch*PH*PW + pr*PW + pc
- done  out  1  frame complete; level signal, held until next start

Behaviour:
- Reset (async, rst_n=0):
  - Returns to IDLE.
  - out_valid=0, out_pixel=0, out_addr=0, done=0.
  - All counters, hold register and line buffer cleared.
  - Reset mid-frame discards all progress.
- FSM IDLE -> RUN -> DONE:
  - IDLE: in_valid ignored. start -> RUN, counters (col c, row r, ch) cleared.
  - RUN: each cycle with in_valid=1 consumes one pixel; cycles with in_valid=0 are bubbles with no state change.
  - The edge that consumes pixel number IN_H*IN_W*CHAN -> DONE, done=1 from that edge.
  - DONE: in_valid ignored. start -> RUN, done=0, counters cleared.
  - start while in RUN: restart (counters cleared, partial results dropped, no done for the aborted frame).
  - start has priority over in_valid in the same cycle; that pixel is not consumed.
- ReLU: relu = (in_pixel < 0) ? 0 : in_pixel. Compare as signed 8-bit.
- Per accepted pixel, when c < 2*PW and r < 2*PH:
  - c even: hold <= relu.
  - c odd: pair = max(hold, relu).
    - r even: linebuf[c>>1] <= pair.
    - r odd: emit max(linebuf[c>>1], pair).
- Pixels with c >= 2*PW or r >= 2*PH (default: column 12) are consumed, advance the counters, and are otherwise discarded.
- Counter wrap:
  - c wraps at IN_W-1, incrementing r.
  - r wraps at IN_H-1, incrementing ch.
  - Line buffer needs no clear between channels (each even row overwrites it).
- Output:
  - Registered; out_valid=1 exactly one cycle after the edge accepting the window's bottom-right pixel.
  - out_pixel and out_addr update with it.
  - out_valid=0 otherwise; out_pixel/out_addr hold their last values.
  - Addresses are emitted strictly increasing 0..PH*PW*CHAN-1, each exactly once per complete frame.
- The final out_valid (addr 419) precedes done, because the last input pixel (r=13, c=12) is discarded.

Test Plan:
- Reset check: rst_n=0 asserted mid-frame -> out_valid=0, out_pixel=0, out_addr=0, done=0 immediately (asynchronously, no clock edge needed); after release, in_valid is ignored until start.
- All-negative frame: start, 1820 pixels of -5 back-to-back -> 420 out_valid pulses, all out_pixel=0, addrs 0..419 in order; done=1 from the edge consuming pixel 1820, held.
- Ramp: in_pixel = r+c, and 127 in column 12 -> addr 0 = 2, addr 41 = 24, ch1 addr 42 = 2. Value 127 is never output. Each out_valid occurs one cycle after the odd-row/odd-col pixel is accepted.
- Bubbles: same ramp with in_valid toggled 1,0,1,0 -> identical value/addr sequence; out_valid count 420; done delayed accordingly.
- Extremes: window {-128, 127, 0, 5} at position (0,0) -> out_pixel=127. Window {-128, -1, -128, -1} -> 0.
- Restart: start again after 500 pixels -> next out_addr=0, no done for the aborted frame. A full 1820-pixel frame then produces 420 outputs and done.
